// File: rtl/mux_packer.sv
// mux_packer: packs characters from one of three selected channels into words, MSB byte first.
// A 0xFA terminator flushes a zero-padded last word, then the packer waits for all channels to go idle.
module mux_packer #(
    parameter int MST_DWIDTH = 32,
    parameter int SYS_DWIDTH = 8
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic [1:0]            select,
    input  logic [SYS_DWIDTH-1:0] data0_i,
    input  logic [SYS_DWIDTH-1:0] data1_i,
    input  logic [SYS_DWIDTH-1:0] data2_i,
    input  logic                  valid0_i,
    input  logic                  valid1_i,
    input  logic                  valid2_i,
    output logic [MST_DWIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  last_o,
    output logic [7:0]            word_cnt_o
);
    localparam logic [SYS_DWIDTH-1:0] TERM = SYS_DWIDTH'(8'hFA);

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t                  r_state, w_next;
    logic [1:0]              r_idx;
    logic [MST_DWIDTH-1:0]   r_shift, r_data, w_merged;
    logic                    r_valid, r_last;
    logic [7:0]              r_cnt;
    logic [SYS_DWIDTH-1:0]   w_byte;
    logic                    w_sel_valid, w_accept, w_term, w_emit, w_idle;

    always_comb begin
        w_byte      = select == 2'd0 ? data0_i : select == 2'd1 ? data1_i : data2_i;
        w_sel_valid = select == 2'd0 ? valid0_i : select == 2'd1 ? valid1_i :
                      select == 2'd2 ? valid2_i : 1'b0;
        w_idle      = !(valid0_i || valid1_i || valid2_i);
        w_accept    = r_state == COLLECT && w_sel_valid;
        w_term      = w_byte == TERM;
        w_emit      = w_accept && (w_term || r_idx == 2'd3);
        // later slots are still zero, so a terminator word needs no extra masking
        w_merged    = r_shift | (MST_DWIDTH'(w_byte) << (SYS_DWIDTH * int'(2'd3 - r_idx)));
    end

    always_comb begin
        w_next = r_state;
        w_next = r_state == COLLECT ? (w_emit && w_term ? DRAIN : COLLECT)
                                    : (w_idle ? COLLECT : DRAIN);
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state <= COLLECT;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_valid <= w_emit;
            r_last  <= w_emit && w_term;
            if (w_emit) begin
                r_data  <= w_merged;
                r_shift <= '0;
                r_idx   <= '0;
                r_cnt   <= r_cnt != 8'hFF ? r_cnt + 8'd1 : r_cnt;
            end else if (w_accept) begin
                r_shift <= w_merged;
                r_idx   <= r_idx + 2'd1;
            end
            if (r_state == DRAIN && w_idle)
                r_cnt <= '0;
        end
    end

    assign data_o     = r_data;
    assign valid_o    = r_valid;
    assign last_o     = r_last;
    assign word_cnt_o = r_cnt;
endmodule

// File: tb/tb_mux_packer.sv
// tb_mux_packer: table-driven directed vectors for mux_packer plus a count-saturation sequence.
module tb_mux_packer;
    logic        clk_sys = 1'b0;
    logic        rst;
    logic [1:0]  select;
    logic [7:0]  data0_i, data1_i, data2_i;
    logic        valid0_i, valid1_i, valid2_i;
    logic [31:0] data_o;
    logic        valid_o, last_o;
    logic [7:0]  word_cnt_o;

    int checks = 0;
    int errors = 0;

    mux_packer #(.MST_DWIDTH(32), .SYS_DWIDTH(8)) dut (
        .clk_sys(clk_sys), .rst(rst), .select(select),
        .data0_i(data0_i), .data1_i(data1_i), .data2_i(data2_i),
        .valid0_i(valid0_i), .valid1_i(valid1_i), .valid2_i(valid2_i),
        .data_o(data_o), .valid_o(valid_o), .last_o(last_o), .word_cnt_o(word_cnt_o)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        r;
        logic [1:0]  sel;
        logic [2:0]  v;
        logic [7:0]  d0, d1, d2;
        logic        ev, el;
        logic [31:0] ed;
        logic [7:0]  ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [1:0] sel, logic [2:0] v, logic [7:0] d0, logic [7:0] d1,
                                logic [7:0] d2, logic ev, logic el, logic [31:0] ed, logic [7:0] ec);
        vec_t x;
        x.r = r; x.sel = sel; x.v = v; x.d0 = d0; x.d1 = d1; x.d2 = d2;
        x.ev = ev; x.el = el; x.ed = ed; x.ec = ec;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // drive one edge's inputs, then sample 1 time unit after that edge
    task automatic step(input logic r, input logic [1:0] sel, input logic [2:0] v,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        rst = r; select = sel;
        valid0_i = v[0]; valid1_i = v[1]; valid2_i = v[2];
        data0_i = d0; data1_i = d1; data2_i = d2;
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        logic [31:0] exp_word;
        logic [7:0]  bt;
        step(1'b1, 2'd3, 3'b000, 8'h00, 8'h00, 8'h00);
        // reset, then full word followed by terminator word
        tbl.push_back(mk(1, 3, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, 3'b010, 8'h00, 8'h11, 8'h00, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, 3'b010, 8'h00, 8'h22, 8'h00, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, 3'b010, 8'h00, 8'h33, 8'h00, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, 3'b010, 8'h00, 8'h44, 8'h00, 1, 0, 32'h11223344, 1));
        tbl.push_back(mk(0, 1, 3'b010, 8'h00, 8'h55, 8'h00, 0, 0, 32'h0, 1));
        tbl.push_back(mk(0, 1, 3'b010, 8'h00, 8'hFA, 8'h00, 1, 1, 32'h55FA0000, 2));
        tbl.push_back(mk(0, 0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 32'h0, 0));
        // terminator as the first byte
        tbl.push_back(mk(0, 0, 3'b001, 8'hFA, 8'h00, 8'h00, 1, 1, 32'hFA000000, 1));
        // drain holds while a channel stays valid
        tbl.push_back(mk(0, 2, 3'b100, 8'h00, 8'h00, 8'h99, 0, 0, 32'h0, 1));
        tbl.push_back(mk(0, 2, 3'b100, 8'h00, 8'h00, 8'h99, 0, 0, 32'h0, 1));
        tbl.push_back(mk(0, 2, 3'b100, 8'h00, 8'h00, 8'h99, 0, 0, 32'h0, 1));
        tbl.push_back(mk(0, 2, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 2, 3'b100, 8'h00, 8'h00, 8'hAA, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 2, 3'b100, 8'h00, 8'h00, 8'hBB, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 2, 3'b100, 8'h00, 8'h00, 8'hCC, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 2, 3'b100, 8'h00, 8'h00, 8'hFA, 1, 1, 32'hAABBCCFA, 1));
        tbl.push_back(mk(0, 3, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 32'h0, 0));
        // channel switch mid-word, select=3 ignores a valid channel
        tbl.push_back(mk(0, 0, 3'b001, 8'h01, 8'h00, 8'h00, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 2, 3'b100, 8'h00, 8'h00, 8'h02, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 3, 3'b010, 8'h00, 8'h77, 8'h00, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 3'b001, 8'h03, 8'h00, 8'h00, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 3'b001, 8'h04, 8'h00, 8'h00, 1, 0, 32'h01020304, 1));
        tbl.push_back(mk(0, 3, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 32'h0, 1));
        // reset mid-word discards the partial word and wins over an accept
        tbl.push_back(mk(0, 0, 3'b001, 8'h10, 8'h00, 8'h00, 0, 0, 32'h0, 1));
        tbl.push_back(mk(0, 0, 3'b001, 8'h20, 8'h00, 8'h00, 0, 0, 32'h0, 1));
        tbl.push_back(mk(1, 0, 3'b001, 8'hFA, 8'h00, 8'h00, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 3'b001, 8'h30, 8'h00, 8'h00, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 3'b001, 8'h40, 8'h00, 8'h00, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 3'b001, 8'h50, 8'h00, 8'h00, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 3'b001, 8'h60, 8'h00, 8'h00, 1, 0, 32'h30405060, 1));
        tbl.push_back(mk(0, 3, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 32'h0, 1));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].sel, tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].d2);
            check($sformatf("vec%0d valid", i), 32'(valid_o), 32'(tbl[i].ev));
            check($sformatf("vec%0d last", i), 32'(last_o), 32'(tbl[i].el));
            check($sformatf("vec%0d cnt", i), 32'(word_cnt_o), 32'(tbl[i].ec));
            if (tbl[i].ev || tbl[i].r)
                check($sformatf("vec%0d data", i), data_o, tbl[i].ed);
        end

        // back-to-back bytes: pulse every 4th cycle, count saturates at 255
        step(1'b1, 2'd3, 3'b000, 8'h00, 8'h00, 8'h00);
        exp_word = '0;
        for (int w = 0; w < 260; w++) begin
            for (int b = 0; b < 4; b++) begin
                bt = 8'((w * 4 + b) & 8'h7F);
                exp_word = {exp_word[23:0], bt};
                step(1'b0, 2'd0, 3'b001, bt, 8'h00, 8'h00);
                if (b == 0 && w > 0)
                    check($sformatf("sat w%0d valid fall", w), 32'(valid_o), 32'd0);
            end
            check($sformatf("sat w%0d valid", w), 32'(valid_o), 32'd1);
            check($sformatf("sat w%0d data", w), data_o, exp_word);
            check($sformatf("sat w%0d cnt", w), 32'(word_cnt_o), w + 1 > 255 ? 32'd255 : 32'(w + 1));
        end
        step(1'b0, 2'd0, 3'b001, 8'hFA, 8'h00, 8'h00);
        check("sat term last", 32'(last_o), 32'd1);
        check("sat term cnt", 32'(word_cnt_o), 32'd255);
        check("sat term data", data_o, 32'hFA000000);
        // minimum gap: exit edge, then an immediate accept
        step(1'b0, 2'd1, 3'b000, 8'h00, 8'h00, 8'h00);
        check("gap exit cnt", 32'(word_cnt_o), 32'd0);
        check("gap exit valid", 32'(valid_o), 32'd0);
        step(1'b0, 2'd1, 3'b010, 8'h00, 8'hFA, 8'h00);
        check("gap accept valid", 32'(valid_o), 32'd1);
        check("gap accept last", 32'(last_o), 32'd1);
        check("gap accept data", data_o, 32'hFA000000);
        check("gap accept cnt", 32'(word_cnt_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
